simproc_host_ctrl: RTL and testbench

//  Host-side controller for the simproc core. It shares the single 8-bit memory port between host and core.
//  It sequences the core debug pins (pc_set_*, run) for free-run, N-step and stop, and counts retired instructions.
//  It sits between a host command channel (UART/JTAG bridge) and the core/memory.

---
 rtl/simproc_pkg.sv | 25 ++
 rtl/simproc_host_ctrl_if.sv | 24 ++
 rtl/simproc_host_ctrl.sv | 145 ++++++++++++++
 tb/tb_simproc_host_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simproc_pkg.sv
// Shared types for the simproc host controller: host opcodes, status selects and FSM states.
package simproc_pkg;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        WR_MEM  = 3'd1,
        RD_MEM  = 3'd2,
        SET_PC  = 3'd3,
        RUN     = 3'd4,
        STOP    = 3'd5,
        RD_STAT = 3'd6,
        CLR_CNT = 3'd7
    } host_op_t;

    localparam logic [1:0] STAT_PC     = 2'd0;
    localparam logic [1:0] STAT_CNT_LO = 2'd1;
    localparam logic [1:0] STAT_CNT_HI = 2'd2;
    localparam logic [1:0] STAT_FLAGS  = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/simproc_host_ctrl_if.sv
// Host command/response channel: one command per valid&&ready, one registered response a cycle later.
interface simproc_host_ctrl_if;
    import simproc_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    host_op_t   cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_err;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_err, rsp_data
    );

endinterface

// File: rtl/simproc_host_ctrl.sv
// Arbitrates the shared memory port between host and core, sequences core run/step/stop
// and counts retired instructions.
module simproc_host_ctrl
    import simproc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    simproc_host_ctrl_if.slave   host,
    output logic                 stopped,
    input  logic [7:0]           core_mem_addr,
    input  logic [7:0]           core_mem_din,
    input  logic                 core_mem_we,
    output logic [7:0]           core_mem_dout,
    output logic [7:0]           mem_addr,
    output logic [7:0]           mem_din,
    output logic                 mem_we,
    input  logic [7:0]           mem_dout,
    output logic [7:0]           pc_set_val,
    output logic                 pc_set_wr,
    output logic                 run,
    input  logic [7:0]           pc_val,
    input  logic                 halt,
    input  logic                 done
);

    ctrl_state_t      state;
    logic [7:0]       step_rem;
    logic             stop_pend;
    logic [CNT_W-1:0] retire_cnt;
    logic [15:0]      cnt_wide;

    logic       accept;
    logic       is_idle;
    logic       stop_now;
    logic       last_instr;
    logic       retire;
    logic       rejected;
    logic [7:0] rsp_data_next;

    // An illegal-opcode halt is not a retire; the core just refetches with run still high.
    logic unused_halt;
    assign unused_halt = halt;

    assign accept     = host.cmd_valid && host.cmd_ready;
    assign is_idle    = (state == S_IDLE);
    assign stop_now   = accept && !is_idle && (host.cmd_op == STOP);
    assign last_instr = stop_pend || stop_now || (step_rem == 8'd1);
    assign retire     = done && !is_idle;
    assign run        = !is_idle && !(done && last_instr);
    assign cnt_wide   = 16'(retire_cnt);

    assign core_mem_dout = mem_dout;
    assign pc_set_wr     = accept && is_idle && (host.cmd_op == SET_PC);
    assign pc_set_val    = pc_set_wr ? host.cmd_data : 8'd0;

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        mem_addr = core_mem_addr;
        mem_din  = core_mem_din;
        mem_we   = core_mem_we;
        if (is_idle) begin
            mem_addr = host.cmd_addr;
            mem_din  = host.cmd_data;
            mem_we   = accept && (host.cmd_op == WR_MEM);
        end
    end

    always_comb begin
        rejected      = !is_idle && (host.cmd_op inside {WR_MEM, RD_MEM, SET_PC, RUN});
        rsp_data_next = 8'd0;
        unique case (host.cmd_op)
            WR_MEM, SET_PC: rsp_data_next = host.cmd_data;
            RD_MEM:         rsp_data_next = mem_dout;
            RD_STAT: begin
                unique case (host.cmd_addr[1:0])
                    STAT_PC:     rsp_data_next = pc_val;
                    STAT_CNT_LO: rsp_data_next = cnt_wide[7:0];
                    STAT_CNT_HI: rsp_data_next = cnt_wide[15:8];
                    STAT_FLAGS:  rsp_data_next = {6'b0, stop_pend, !is_idle};
                    default:     rsp_data_next = 8'd0;
                endcase
            end
            default:        rsp_data_next = 8'd0;
        endcase
        if (rejected) begin
            rsp_data_next = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            step_rem       <= 8'd0;
            stop_pend      <= 1'b0;
            retire_cnt     <= '0;
            stopped        <= 1'b0;
            host.cmd_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_err   <= 1'b0;
            host.rsp_data  <= 8'd0;
        end else begin
            host.cmd_ready <= 1'b1;
            host.rsp_valid <= accept;
            host.rsp_err   <= accept && rejected;
            host.rsp_data  <= accept ? rsp_data_next : 8'd0;
            stopped        <= 1'b0;

            // Clear wins over a coincident retire.
            if (accept && (host.cmd_op == CLR_CNT)) begin
                retire_cnt <= '0;
            end else if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end

            unique case (state)
                S_IDLE: begin
                    if (accept && (host.cmd_op == RUN)) begin
                        step_rem <= host.cmd_data;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (retire && last_instr) begin
                        state     <= S_IDLE;
                        stopped   <= 1'b1;
                        stop_pend <= 1'b0;
                        step_rem  <= 8'd0;
                    end else begin
                        if (retire && (step_rem != 8'd0)) begin
                            step_rem <= step_rem - 8'd1;
                        end
                        if (stop_now) begin
                            stop_pend <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simproc_host_ctrl.sv
// Directed bench for simproc_host_ctrl with a small behavioural core and 256-byte memory.
module tb_simproc_host_ctrl;
    import simproc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simproc_host_ctrl_if host_bus ();

    logic       stopped;
    logic [7:0] core_mem_addr, core_mem_din, core_mem_dout;
    logic       core_mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic       mem_we;
    logic [7:0] pc_set_val;
    logic       pc_set_wr, run, halt, done;
    logic [7:0] pc_val;

    simproc_host_ctrl #(.CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .host          (host_bus),
        .stopped       (stopped),
        .core_mem_addr (core_mem_addr),
        .core_mem_din  (core_mem_din),
        .core_mem_we   (core_mem_we),
        .core_mem_dout (core_mem_dout),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_we        (mem_we),
        .mem_dout      (mem_dout),
        .pc_set_val    (pc_set_val),
        .pc_set_wr     (pc_set_wr),
        .run           (run),
        .pc_val        (pc_val),
        .halt          (halt),
        .done          (done)
    );

    // Memory: asynchronous read, synchronous write.
    logic [7:0] mem [256];
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

    // Core: opcode 0x00 nop, 0x01 store pc to mem[0x30], bit7 set = jump to op[6:0].
    // Slow mode: fetch cycle then retire cycle; fast mode: back-to-back retires.
    logic [7:0] pc, op;
    logic       ph, fast;
    assign done          = ph;
    assign halt          = ~(ph | run);
    assign pc_val        = pc;
    assign core_mem_we   = ph && (op == 8'h01);
    assign core_mem_addr = core_mem_we ? 8'h30 : pc;
    assign core_mem_din  = pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 1'b0;
            pc <= 8'd0;
            op <= 8'd0;
        end else if (pc_set_wr) begin
            pc <= pc_set_val;
            ph <= 1'b0;
        end else if (ph) begin
            pc <= op[7] ? {1'b0, op[6:0]} : pc + 8'd1;
            ph <= fast && run;
        end else if (run) begin
            op <= core_mem_dout;
            ph <= 1'b1;
        end
    end

    int done_cnt = 0;
    int stopped_cnt = 0;
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (stopped) stopped_cnt <= stopped_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input host_op_t o, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic re, output logic rv);
        @(negedge clk);
        host_bus.cmd_valid = 1'b1;
        host_bus.cmd_op    = o;
        host_bus.cmd_addr  = a;
        host_bus.cmd_data  = d;
        @(posedge clk);
        #1;
        host_bus.cmd_valid = 1'b0;
        rd = host_bus.rsp_data;
        re = host_bus.rsp_err;
        rv = host_bus.rsp_valid;
    endtask

    task automatic wait_stopped(input int budget, output logic ok);
        int s0;
        s0 = stopped_cnt;
        for (int i = 0; i < budget && stopped_cnt == s0; i++) @(posedge clk);
        #1;
        ok = (stopped_cnt == s0 + 1);
    endtask

    logic [7:0] rd;
    logic       re, rv, ok, all_ok, found;
    int         d0, s0;

    initial begin
        rst = 1'b1;
        fast = 1'b0;
        host_bus.cmd_valid = 1'b0;
        host_bus.cmd_op    = NOP;
        host_bus.cmd_addr  = 8'd0;
        host_bus.cmd_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", host_bus.cmd_ready, 0);
        check("rst_run", run, 0);
        check("rst_rsp_valid", host_bus.rsp_valid, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", host_bus.cmd_ready, 1);

        // Host memory access
        send(WR_MEM, 8'h10, 8'h5A, rd, re, rv);
        check("wr_rsp_valid", rv, 1);
        check("wr_rsp_data", rd, 8'h5A);
        send(RD_MEM, 8'h10, 8'h00, rd, re, rv);
        check("rd_rsp_valid", rv, 1);
        check("rd_rsp_data", rd, 8'h5A);
        check("rd_rsp_err", re, 0);
        @(posedge clk);
        #1;
        check("rsp_one_cycle", host_bus.rsp_valid, 0);

        // Three-step run over nops, with a jump-to-self parked at 3
        send(WR_MEM, 8'h00, 8'h00, rd, re, rv);
        send(WR_MEM, 8'h01, 8'h00, rd, re, rv);
        send(WR_MEM, 8'h02, 8'h00, rd, re, rv);
        send(WR_MEM, 8'h03, 8'h83, rd, re, rv);
        send(SET_PC, 8'h00, 8'h00, rd, re, rv);
        check("setpc_rsp_err", re, 0);
        send(CLR_CNT, 8'h00, 8'h00, rd, re, rv);
        d0 = done_cnt;
        send(RUN, 8'h00, 8'd3, rd, re, rv);
        check("run3_rsp_data", rd, 8'h00);
        wait_stopped(40, ok);
        check("run3_stopped", ok, 1);
        repeat (3) @(posedge clk);
        #1;
        check("run3_done_pulses", 16'(done_cnt - d0), 3);
        send(RD_STAT, 8'd1, 8'h00, rd, re, rv);
        check("run3_cnt_lo", rd, 8'd3);
        send(RD_STAT, 8'd0, 8'h00, rd, re, rv);
        check("run3_pc", rd, 8'd3);
        send(RD_STAT, 8'd2, 8'h00, rd, re, rv);
        check("run3_cnt_hi", rd, 8'd0);
        send(RD_STAT, 8'd3, 8'h00, rd, re, rv);
        check("run3_flags", rd, 8'd0);

        // Free run on the jump-to-self, then STOP
        send(RUN, 8'h00, 8'd0, rd, re, rv);
        repeat (50) @(posedge clk);
        send(RD_STAT, 8'd3, 8'h00, rd, re, rv);
        check("free_running_flag", rd, 8'd1);
        d0 = done_cnt;
        send(STOP, 8'h00, 8'h00, rd, re, rv);
        check("free_stop_err", re, 0);
        wait_stopped(6, ok);
        check("free_stopped", ok, 1);
        repeat (3) @(posedge clk);
        #1;
        check("free_stop_one_instr", (done_cnt - d0) <= 2, 1);
        send(RD_STAT, 8'd3, 8'h00, rd, re, rv);
        check("free_flags_idle", rd, 8'd0);

        // STOP arriving in the same cycle as a retire
        send(RUN, 8'h00, 8'd0, rd, re, rv);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        check("coinc_done_seen", found, 1);
        s0 = stopped_cnt;
        host_bus.cmd_valid = 1'b1;
        host_bus.cmd_op    = STOP;
        #1;
        check("coinc_run_low", run, 0);
        @(posedge clk);
        #1;
        host_bus.cmd_valid = 1'b0;
        check("coinc_rsp_valid", host_bus.rsp_valid, 1);
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        check("coinc_no_more_done", 16'(done_cnt - d0), 0);
        check("coinc_stopped", 16'(stopped_cnt - s0), 1);

        // Host access rejected while the core owns memory
        send(WR_MEM, 8'h40, 8'h01, rd, re, rv);
        send(WR_MEM, 8'h41, 8'hC0, rd, re, rv);
        send(WR_MEM, 8'h30, 8'h00, rd, re, rv);
        send(WR_MEM, 8'h20, 8'h77, rd, re, rv);
        send(SET_PC, 8'h00, 8'h40, rd, re, rv);
        send(RUN, 8'h00, 8'd0, rd, re, rv);
        repeat (10) @(posedge clk);
        send(WR_MEM, 8'h20, 8'hEE, rd, re, rv);
        check("run_wr_err", re, 1);
        check("run_wr_data", rd, 8'h00);
        send(RD_MEM, 8'h20, 8'h00, rd, re, rv);
        check("run_rd_err", re, 1);
        send(SET_PC, 8'h00, 8'h00, rd, re, rv);
        check("run_setpc_err", re, 1);
        send(RUN, 8'h00, 8'd1, rd, re, rv);
        check("run_run_err", re, 1);
        send(STOP, 8'h00, 8'h00, rd, re, rv);
        check("run_stop_err", re, 0);
        wait_stopped(6, ok);
        check("run_stopped", ok, 1);
        send(RD_MEM, 8'h20, 8'h00, rd, re, rv);
        check("mem20_unchanged", rd, 8'h77);
        send(RD_MEM, 8'h30, 8'h00, rd, re, rv);
        check("core_store_seen", rd, 8'h40);

        // Counter wrap: 257 runs of 255 retires reach 0xFFFF, one more step wraps
        send(WR_MEM, 8'h50, 8'hD0, rd, re, rv);
        send(SET_PC, 8'h00, 8'h50, rd, re, rv);
        send(CLR_CNT, 8'h00, 8'h00, rd, re, rv);
        fast = 1'b1;
        all_ok = 1'b1;
        for (int i = 0; i < 257; i++) begin
            send(RUN, 8'h00, 8'd255, rd, re, rv);
            wait_stopped(300, ok);
            all_ok = all_ok & ok;
        end
        check("preload_all_stopped", all_ok, 1);
        send(RD_STAT, 8'd1, 8'h00, rd, re, rv);
        check("preload_cnt_lo", rd, 8'hFF);
        send(RD_STAT, 8'd2, 8'h00, rd, re, rv);
        check("preload_cnt_hi", rd, 8'hFF);
        send(RUN, 8'h00, 8'd1, rd, re, rv);
        wait_stopped(20, ok);
        check("wrap_stopped", ok, 1);
        send(RD_STAT, 8'd1, 8'h00, rd, re, rv);
        check("wrap_cnt_lo", rd, 8'h00);
        send(RD_STAT, 8'd2, 8'h00, rd, re, rv);
        check("wrap_cnt_hi", rd, 8'h00);
        fast = 1'b0;

        // Asynchronous reset mid-run with a response in flight
        send(SET_PC, 8'h00, 8'h03, rd, re, rv);
        send(RUN, 8'h00, 8'd0, rd, re, rv);
        repeat (5) @(posedge clk);
        s0 = stopped_cnt;
        @(negedge clk);
        host_bus.cmd_valid = 1'b1;
        host_bus.cmd_op    = RD_STAT;
        host_bus.cmd_addr  = 8'd1;
        @(posedge clk);
        #1;
        host_bus.cmd_valid = 1'b0;
        check("pre_rst_rsp_valid", host_bus.rsp_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_run", run, 0);
        check("rst_rsp_dropped", host_bus.rsp_valid, 0);
        check("rst_mid_ready", host_bus.cmd_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_ready", host_bus.cmd_ready, 1);
        check("rst_no_stopped", 16'(stopped_cnt - s0), 0);
        send(RD_STAT, 8'd3, 8'h00, rd, re, rv);
        check("rst_flags_idle", rd, 8'd0);
        send(RD_STAT, 8'd1, 8'h00, rd, re, rv);
        check("rst_cnt_cleared", rd, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
